// File: rtl/painterengine_gpu_dvi_capture_pkg.sv
// Shared definitions for the DVI capture path: FSM encodings, rgba packing modes, helpers.
package painterengine_gpu_dvi_capture_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSync    = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

  // Same packing codes as the DVI output side.
  localparam logic [2:0] RgbaModeRgb    = 3'd0;
  localparam logic [2:0] RgbaModeGrb    = 3'd1;
  localparam logic [2:0] RgbaModeBgr    = 3'd2;
  localparam logic [2:0] RgbaModeBgrAlt = 3'd3;

  function automatic logic [31:0] pack_rgba(input logic [2:0] mode, input logic [23:0] rgb);
    logic [31:0] word;
    case (mode)
      RgbaModeRgb:                 word = {rgb[23:16], rgb[15:8], rgb[7:0], 8'hFF};
      RgbaModeGrb:                 word = {rgb[15:8], rgb[23:16], rgb[7:0], 8'hFF};
      RgbaModeBgr, RgbaModeBgrAlt: word = {rgb[7:0], rgb[15:8], rgb[23:16], 8'hFF};
      default:                     word = 32'h0;
    endcase
    return word;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/painterengine_gpu_dvi_capture_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO succeeds only with a pop.
module painterengine_gpu_dvi_capture_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 64
) (
  input  logic             i_wire_clock,
  input  logic             i_wire_resetn,
  input  logic             i_wire_push,
  input  logic [Width-1:0] i_wire_wdata,
  input  logic             i_wire_pop,
  output logic [Width-1:0] o_wire_rdata,
  output logic             o_wire_full,
  output logic             o_wire_empty
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign o_wire_empty = (wptr_q == rptr_q);
  assign o_wire_full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                        (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_pop       = i_wire_pop & ~o_wire_empty;
  assign do_push      = i_wire_push & (~o_wire_full | do_pop);
  assign o_wire_rdata = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= i_wire_wdata;
  end

endmodule

// File: rtl/painterengine_gpu_dvi_capture.sv
// DVI receive capture: syncs to frames, measures resolution, packs pixels into a valid/ready stream.
module painterengine_gpu_dvi_capture
  import painterengine_gpu_dvi_capture_pkg::*;
#(
  parameter int unsigned PARAM_DATA_WIDTH = 32,
  parameter int unsigned PARAM_FIFO_DEPTH = 64
) (
  input  logic                        i_wire_pixel_clock,
  input  logic                        i_wire_resetn,
  input  logic                        i_wire_enable,
  input  logic                        i_wire_single,
  input  logic                        i_wire_hs_pol,
  input  logic                        i_wire_vs_pol,
  input  logic                        i_wire_hs,
  input  logic                        i_wire_vs,
  input  logic                        i_wire_de,
  input  logic [23:0]                 i_wire_rgb,
  input  logic [2:0]                  i_wire_rgba_mode,
  input  logic [15:0]                 i_wire_clip_width,
  input  logic [15:0]                 i_wire_clip_height,
  output logic [PARAM_DATA_WIDTH-1:0] o_wire_rgba,
  output logic                        o_wire_sof,
  output logic                        o_wire_eol,
  output logic                        o_wire_valid,
  input  logic                        i_wire_ready,
  output logic [15:0]                 o_wire_width,
  output logic [15:0]                 o_wire_height,
  output logic                        o_wire_locked,
  output logic                        o_wire_overflow,
  output logic                        o_wire_done
);
  localparam int unsigned EntryW = PARAM_DATA_WIDTH + 2;

  cap_state_e        state_q, state_d;
  logic              s1_vs_act, s1_de, s2_vs_act, s2_de;
  logic [23:0]       s1_rgb, s2_rgb;
  logic [15:0]       x_q, y_q, y_cur, w_cur, prev_w_q, prev_h_q;
  logic              frame_start, line_end, push_s2, eol_s2, sof_pend_q;
  logic              push_q, enable_q, overflow_q, locked_q;
  logic [EntryW-1:0] entry_q, fifo_rdata;
  logic              fifo_full, fifo_empty, pop;
  logic              unused_hs;

  // Line sync is recovered from DE alone.
  assign unused_hs = i_wire_hs ^ i_wire_hs_pol;

  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      s1_vs_act <= 1'b0;
      s1_de     <= 1'b0;
      s1_rgb    <= '0;
      s2_vs_act <= 1'b0;
      s2_de     <= 1'b0;
      s2_rgb    <= '0;
    end else begin
      s1_vs_act <= (i_wire_vs == i_wire_vs_pol);
      s1_de     <= i_wire_de;
      s1_rgb    <= i_wire_rgb;
      s2_vs_act <= s1_vs_act;
      s2_de     <= s1_de;
      s2_rgb    <= s1_rgb;
    end
  end

  // S2 holds the pixel being processed; S1 is the look-ahead sample.
  assign frame_start = s1_vs_act & ~s2_vs_act;
  assign line_end    = s2_de & ~s1_de;
  assign y_cur       = line_end ? sat_inc(y_q) : y_q;
  assign w_cur       = line_end ? sat_inc(x_q) : o_wire_width;

  always_comb begin
    state_d = state_q;
    if (!i_wire_enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StSync;
        StSync:    if (frame_start) state_d = StCapture;
        StCapture: if (frame_start && i_wire_single) state_d = StDone;
        StDone:    state_d = StDone;
        default:   state_d = StIdle;
      endcase
    end
  end

  assign push_s2 = (state_q == StCapture) && s2_de &&
                   (x_q < i_wire_clip_width) && (y_q < i_wire_clip_height);
  assign eol_s2  = (x_q == i_wire_clip_width - 16'd1) || !s1_de;

  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      sof_pend_q <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= s2_de ? sat_inc(x_q) : 16'd0;
      if (frame_start)   y_q <= '0;
      else if (line_end) y_q <= sat_inc(y_q);
      if (frame_start)   sof_pend_q <= 1'b1;
      else if (push_s2)  sof_pend_q <= 1'b0;
      push_q  <= push_s2;
      entry_q <= {sof_pend_q, eol_s2, pack_rgba(i_wire_rgba_mode, s2_rgb)};
    end
  end

  // Measurement runs regardless of capture state; only lock status depends on enable.
  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      o_wire_width  <= '0;
      o_wire_height <= '0;
      prev_w_q      <= '0;
      prev_h_q      <= '0;
      locked_q      <= 1'b0;
    end else begin
      if (line_end) o_wire_width <= sat_inc(x_q);
      if (frame_start && y_cur != 16'd0) begin
        o_wire_height <= y_cur;
        prev_w_q      <= w_cur;
        prev_h_q      <= y_cur;
      end
      if (!i_wire_enable) begin
        locked_q <= 1'b0;
      end else if (frame_start && y_cur != 16'd0) begin
        locked_q <= (y_cur == prev_h_q) && (w_cur == prev_w_q);
      end
    end
  end

  assign pop = o_wire_valid & i_wire_ready;

  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      enable_q <= i_wire_enable;
      if (i_wire_enable && !enable_q)        overflow_q <= 1'b0;
      else if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  painterengine_gpu_dvi_capture_fifo #(
    .Width (EntryW),
    .Depth (PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_clock  (i_wire_pixel_clock),
    .i_wire_resetn (i_wire_resetn),
    .i_wire_push   (push_q),
    .i_wire_wdata  (entry_q),
    .i_wire_pop    (i_wire_ready),
    .o_wire_rdata  (fifo_rdata),
    .o_wire_full   (fifo_full),
    .o_wire_empty  (fifo_empty)
  );

  assign o_wire_valid    = ~fifo_empty;
  assign o_wire_rgba     = o_wire_valid ? fifo_rdata[PARAM_DATA_WIDTH-1:0] : '0;
  assign o_wire_eol      = o_wire_valid & fifo_rdata[PARAM_DATA_WIDTH];
  assign o_wire_sof      = o_wire_valid & fifo_rdata[PARAM_DATA_WIDTH+1];
  assign o_wire_locked   = locked_q;
  assign o_wire_overflow = overflow_q;
  assign o_wire_done     = (state_q == StDone);

endmodule

// File: tb/tb_painterengine_gpu_dvi_capture.sv
// Directed bench: drives small DVI frames, scoreboards packed words and measurement outputs.
module tb_painterengine_gpu_dvi_capture;

  logic        clk = 1'b0;
  logic        rst_n, enable, single, hs_pol, vs_pol, hs, vs, de, ready;
  logic [23:0] rgb;
  logic [2:0]  mode;
  logic [15:0] clip_w, clip_h;
  logic [31:0] rgba;
  logic        sof, eol, valid, locked, overflow, done;
  logic [15:0] width, height;

  logic [33:0] exp_q[$];
  logic [33:0] exp_w;
  int          vecs = 0, errs = 0, pops = 0, cyc = 0, room = -1, p0 = 0, lat_exp = 0;
  bit          lat_armed = 0, lat_first = 0, sof_pend_m = 0;

  painterengine_gpu_dvi_capture dut (
    .i_wire_pixel_clock (clk),
    .i_wire_resetn      (rst_n),
    .i_wire_enable      (enable),
    .i_wire_single      (single),
    .i_wire_hs_pol      (hs_pol),
    .i_wire_vs_pol      (vs_pol),
    .i_wire_hs          (hs),
    .i_wire_vs          (vs),
    .i_wire_de          (de),
    .i_wire_rgb         (rgb),
    .i_wire_rgba_mode   (mode),
    .i_wire_clip_width  (clip_w),
    .i_wire_clip_height (clip_h),
    .o_wire_rgba        (rgba),
    .o_wire_sof         (sof),
    .o_wire_eol         (eol),
    .o_wire_valid       (valid),
    .i_wire_ready       (ready),
    .o_wire_width       (width),
    .o_wire_height      (height),
    .o_wire_locked      (locked),
    .o_wire_overflow    (overflow),
    .o_wire_done        (done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack_m(input logic [2:0] m, input logic [23:0] c);
    case (m)
      3'd0:       return {c[23:16], c[15:8], c[7:0], 8'hFF};
      3'd1:       return {c[15:8], c[23:16], c[7:0], 8'hFF};
      3'd2, 3'd3: return {c[7:0], c[15:8], c[23:16], 8'hFF};
      default:    return 32'h0;
    endcase
  endfunction

  // Scoreboard consumer: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (lat_armed && (valid || cyc > lat_exp)) begin
      lat_armed = 0;
      check("latency_cycle", cyc, lat_exp);
    end
    if (rst_n && valid && ready) begin
      pops++;
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("word", {sof, eol, rgba}, exp_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    de = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_vs();
    de = 0;
    vs = vs_pol;
    tick();
    tick();
    vs = ~vs_pol;
    tick();
    tick();
    sof_pend_m = 1;
  endtask

  task automatic drive_pixel(input int x, input int y, input int w, input logic [23:0] base,
                             input bit expect_push);
    de  = 1;
    rgb = base ^ {8'(x), 8'(y), 8'h00};
    if (expect_push && x < int'(clip_w) && y < int'(clip_h) && room != 0) begin
      if (room > 0) room--;
      exp_q.push_back({sof_pend_m, (x == int'(clip_w) - 1) || (x == w - 1), pack_m(mode, rgb)});
      sof_pend_m = 0;
      if (lat_first) begin
        lat_first = 0;
        lat_exp   = cyc + 4;
        lat_armed = 1;
      end
    end
    tick();
  endtask

  task automatic send_line(input int w, input int y, input logic [23:0] base, input bit e);
    de = 0;
    hs = hs_pol;
    tick();
    tick();
    hs = ~hs_pol;
    tick();
    tick();
    for (int x = 0; x < w; x++) drive_pixel(x, y, w, base, e);
    idle(2);
  endtask

  task automatic send_frame(input int w, input int h, input logic [23:0] base, input bit e);
    drive_vs();
    idle(2);
    for (int y = 0; y < h; y++) send_line(w, y, base, e);
    idle(4);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
    check("drain_remaining", exp_q.size(), 0);
    idle(3);
  endtask

  initial begin
    rst_n = 0; enable = 0; single = 0; hs_pol = 1; vs_pol = 1; hs = 0; vs = 0; de = 0;
    rgb = '0; mode = 3'd0; clip_w = 16'd8; clip_h = 16'd4; ready = 1;
    idle(3);
    check("reset_outputs", {rgba, sof, eol, valid, width, height, locked, overflow, done}, '0);
    rst_n = 1;
    tick();
    enable = 1;
    idle(2);

    // 8x4 frame, mode0, first-pixel latency
    p0 = pops;
    lat_first = 1;
    send_frame(8, 4, 24'h112233, 1);
    wait_drain();
    check("t1_words", pops - p0, 32);
    check("t1_width", width, 8);

    // Continuous frames and lock tracking
    send_frame(8, 4, 24'h405060, 1);
    check("t2_height", height, 4);
    check("t2_unlocked_first", locked, 0);
    send_frame(8, 4, 24'h0A0B0C, 1);
    check("t2_locked", locked, 1);
    send_frame(6, 4, 24'h102030, 1);
    check("t2_width6", width, 6);
    check("t2_still_locked", locked, 1);
    send_frame(6, 4, 24'h203040, 1);
    check("t2_lock_lost", locked, 0);
    send_frame(6, 4, 24'h304050, 1);
    check("t2_relock", locked, 1);
    wait_drain();

    // Clipping and packing modes
    clip_w = 16'd5; clip_h = 16'd2; mode = 3'd1;
    p0 = pops;
    send_frame(8, 4, 24'h112233, 1);
    wait_drain();
    check("t3_clip_words", pops - p0, 10);
    mode = 3'd2;
    send_frame(8, 4, 24'h112233, 1);
    mode = 3'd5;
    send_frame(8, 4, 24'h112233, 1);
    wait_drain();
    clip_w = 16'd0; clip_h = 16'd0; mode = 3'd0;
    p0 = pops;
    send_frame(8, 4, 24'h445566, 1);
    check("t3_clip0_valid", valid, 0);
    check("t3_clip0_words", pops - p0, 0);

    // FIFO overflow with consumer stalled
    clip_w = 16'd100; clip_h = 16'd100;
    ready = 0;
    room  = 64;
    send_frame(10, 7, 24'hA0B0C0, 1);
    check("t4_valid_held", valid, 1);
    check("t4_overflow", overflow, 1);
    room  = -1;
    ready = 1;
    p0 = pops;
    wait_drain();
    check("t4_drained", pops - p0, 64);

    // Single-frame capture
    enable = 0;
    single = 1;
    idle(2);
    check("t5_locked_cleared", locked, 0);
    check("t5_overflow_sticky", overflow, 1);
    enable = 1;
    idle(2);
    check("t5_overflow_cleared", overflow, 0);
    p0 = pops;
    send_frame(8, 4, 24'h778899, 1);
    check("t5_not_done_yet", done, 0);
    send_frame(8, 4, 24'h665544, 0);
    check("t5_done", done, 1);
    wait_drain();
    check("t5_words", pops - p0, 32);
    enable = 0;
    idle(2);
    check("t5_done_cleared", done, 0);

    // Enable raised mid-frame waits for the next frame start
    single = 0;
    p0 = pops;
    drive_vs();
    idle(2);
    send_line(8, 0, 24'h010203, 0);
    send_line(8, 1, 24'h010203, 0);
    enable = 1;
    send_line(8, 2, 24'h010203, 0);
    send_line(8, 3, 24'h010203, 0);
    idle(4);
    check("t6_no_midframe_push", pops - p0, 0);
    check("t6_no_midframe_valid", valid, 0);
    send_frame(8, 4, 24'hC0FFEE, 1);
    wait_drain();

    // Asynchronous reset in the middle of a line
    drive_vs();
    idle(2);
    for (int x = 0; x < 5; x++) drive_pixel(x, 0, 8, 24'h123456, 1);
    #2;
    rst_n = 0;
    exp_q.delete();
    @(negedge clk);
    check("t6_reset_outputs", {rgba, sof, eol, valid, width, height, locked, overflow, done}, '0);
    de = 0;
    tick();
    rst_n = 1;
    idle(4);
    check("t6_empty_after_reset", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
